// File: rtl/alu_fpga_pkg.sv
// Types and constants for the sequential ALU bring-up wrapper:
// one-hot entry state, latched flag bundle and seven-segment glyph table.
package alu_fpga_pkg;

    // One-hot so the state can be shown directly on LEDG[3:0].
    typedef enum logic [3:0] {
        LOAD_A  = 4'b0001,
        LOAD_B  = 4'b0010,
        LOAD_OP = 4'b0100,
        SHOW    = 4'b1000
    } fpga_state_t;

    // Packed so that it maps straight onto LEDG[6:4].
    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

    // Active-low segments, bit 6 = g ... bit 0 = a (DE2 board glyphs).
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and ALU opcode.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/alu_if.sv
// Bundle between a driver and the ALU: operands, opcode, result and flags.
interface alu_if;

    cpu_types_pkg::word_t  a;
    cpu_types_pkg::word_t  b;
    cpu_types_pkg::aluop_t op;
    cpu_types_pkg::word_t  result;
    logic                  zero;
    logic                  negative;
    logic                  overflow;

    modport alu    (input a, b, op, output result, zero, negative, overflow);
    modport master (output a, b, op, input result, zero, negative, overflow);

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU. Overflow is meaningful only for ADD/SUB.
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu bus
);

    word_t res;
    logic  ovf;

    // Operation select and signed-overflow detection.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                res = bus.a + bus.b;
                ovf = (bus.a[31] == bus.b[31]) && (res[31] != bus.a[31]);
            end
            ALU_SUB: begin
                res = bus.a - bus.b;
                ovf = (bus.a[31] != bus.b[31]) && (res[31] != bus.a[31]);
            end
            ALU_AND:  res = bus.a & bus.b;
            ALU_OR:   res = bus.a | bus.b;
            ALU_XOR:  res = bus.a ^ bus.b;
            ALU_SLL:  res = bus.a << bus.b[4:0];
            ALU_SRL:  res = bus.a >> bus.b[4:0];
            ALU_SRA:  res = word_t'($signed(bus.a) >>> bus.b[4:0]);
            ALU_SLT:  res = word_t'($signed(bus.a) < $signed(bus.b));
            ALU_SLTU: res = word_t'(bus.a < bus.b);
            default:  res = '0;
        endcase
    end

    assign bus.result   = res;
    assign bus.zero     = (res == '0);
    assign bus.negative = res[31];
    assign bus.overflow = ovf;

endmodule

// File: rtl/alu_fpga_seq_hex7seg.sv
// Nibble to active-low seven-segment decoder (0..F).
module hex7seg
    import alu_fpga_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/alu_fpga_seq.sv
// Sequential FPGA bring-up wrapper for the ALU. Operands A, B and the opcode
// are entered from the switches one step per advance key press; the latched
// result is shown on DIGITS seven-segment digits with paging.
// Optional build macro: ALU_FPGA_DEBOUNCE_EN adds a DEB_CYCLES stability
// filter on each synchronized key before edge detection.
module alu_fpga_seq
    import cpu_types_pkg::*;
    import alu_fpga_pkg::*;
#(
    parameter int SW_W       = 18,
    parameter int DIGITS     = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [SW_W-1:0]   SW,
    input  logic [3:0]        KEY,
    output logic [DIGITS*7-1:0] HEX,
    output logic [7:0]        LEDG
);

    localparam int DW     = SW_W - 1;
    localparam int NPAGES = 8 / DIGITS;

    // ------------------------------------------------------------------
    // Key front end: synchronizer, optional debounce, falling-edge pulse
    // ------------------------------------------------------------------
    logic [3:0] key_meta_reg;
    logic [3:0] key_sync_reg;
    logic [3:0] key_lvl;
    logic [3:0] key_prev_reg;
    logic [3:0] press;

    // Two-flop synchronizer; released (1) out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_meta_reg <= 4'hF;
            key_sync_reg <= 4'hF;
        end else begin
            key_meta_reg <= KEY;
            key_sync_reg <= key_meta_reg;
        end
    end

`ifdef ALU_FPGA_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          lvl_reg;

            // Accept a new level only after DEB_CYCLES consecutive samples.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_reg <= '0;
                    lvl_reg <= 1'b1;
                end else if (key_sync_reg[gi] != lvl_reg) begin
                    if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                        lvl_reg <= key_sync_reg[gi];
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign key_lvl[gi] = lvl_reg;
        end
    endgenerate
`else
    assign key_lvl = key_sync_reg;

    logic unused_deb;
    assign unused_deb = (DEB_CYCLES != 0);
`endif

    // Previous filtered level for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_prev_reg <= 4'hF;
        end else begin
            key_prev_reg <= key_lvl;
        end
    end

    // One-cycle pulse on each 1->0 transition of the filtered level.
    assign press = key_prev_reg & ~key_lvl;

    logic adv;
    logic clr;
    logic pg;
    logic unused_key3;
    assign adv         = press[0];
    assign clr         = press[1];
    assign pg          = press[2];
    assign unused_key3 = press[3];

    // ------------------------------------------------------------------
    // Operand value from the switches
    // ------------------------------------------------------------------
    logic [DW-1:0] sw_data;
    word_t         swval;

    assign sw_data = SW[DW-1:0];
    assign swval   = SW[SW_W-1] ? word_t'($signed(sw_data)) : word_t'(sw_data);

    // ------------------------------------------------------------------
    // Entry FSM, operand/result registers and ALU
    // ------------------------------------------------------------------
    fpga_state_t state_reg;
    word_t       rega_reg;
    word_t       regb_reg;
    aluop_t      regop_reg;
    word_t       resreg_reg;
    flags_t      flagreg_reg;
    logic [2:0]  page_reg;
    logic        cap_reg;

    alu_if alu_bus ();

    assign alu_bus.a  = rega_reg;
    assign alu_bus.b  = regb_reg;
    assign alu_bus.op = regop_reg;

    alu u_alu (
        .bus (alu_bus)
    );

    // State sequencing; clear beats advance beats page. Result is latched
    // the cycle after SHOW entry so it reflects the freshly loaded opcode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= LOAD_A;
            rega_reg    <= '0;
            regb_reg    <= '0;
            regop_reg   <= ALU_ADD;
            resreg_reg  <= '0;
            flagreg_reg <= '0;
            page_reg    <= '0;
            cap_reg     <= 1'b0;
        end else if (clr) begin
            state_reg   <= LOAD_A;
            rega_reg    <= '0;
            regb_reg    <= '0;
            regop_reg   <= ALU_ADD;
            resreg_reg  <= '0;
            flagreg_reg <= '0;
            page_reg    <= '0;
            cap_reg     <= 1'b0;
        end else begin
            cap_reg <= 1'b0;
            if (cap_reg) begin
                resreg_reg  <= alu_bus.result;
                flagreg_reg <= '{ovf: alu_bus.overflow,
                                  neg: alu_bus.negative,
                                  zero: alu_bus.zero};
            end
            if (adv) begin
                case (state_reg)
                    LOAD_A: begin
                        rega_reg  <= swval;
                        state_reg <= LOAD_B;
                    end
                    LOAD_B: begin
                        regb_reg  <= swval;
                        state_reg <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        regop_reg <= aluop_t'(SW[3:0]);
                        state_reg <= SHOW;
                        page_reg  <= '0;
                        cap_reg   <= 1'b1;
                    end
                    SHOW:    state_reg <= LOAD_A;
                    default: state_reg <= LOAD_A;
                endcase
            end else if (pg && (state_reg == SHOW)) begin
                if (page_reg == 3'(NPAGES - 1)) begin
                    page_reg <= '0;
                end else begin
                    page_reg <= page_reg + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
    word_t               src_word;
    logic [3:0]          src_nib [8];
    logic [DIGITS*7-1:0] seg_w;

    // Select what the digits show for the current state.
    always_comb begin
        src_word = swval;
        case (state_reg)
            LOAD_A, LOAD_B: src_word = swval;
            LOAD_OP:        src_word = {28'd0, SW[3:0]};
            SHOW:           src_word = resreg_reg;
            default:        src_word = swval;
        endcase
    end

    genvar gn;
    generate
        for (gn = 0; gn < 8; gn++) begin : g_nib
            assign src_nib[gn] = src_word[4*gn +: 4];
        end

        for (gn = 0; gn < DIGITS; gn++) begin : g_dig
            logic [2:0] nib_idx;
            assign nib_idx = 3'(32'(page_reg) * DIGITS + gn);

            hex7seg u_seg (
                .nib (src_nib[nib_idx]),
                .seg (seg_w[7*gn +: 7])
            );
        end
    endgenerate

    // Registered outputs: blank digits and LOAD_A indication out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            HEX  <= '1;
            LEDG <= 8'h01;
        end else begin
            HEX  <= seg_w;
            LEDG <= {(page_reg != 3'd0),
                     (state_reg == SHOW) ? flagreg_reg : flags_t'(3'b000),
                     state_reg};
        end
    end

endmodule

// File: tb/tb_alu_fpga_seq.sv
// Directed bench for alu_fpga_seq: an 8-digit/18-switch instance and a
// 4-digit/33-switch instance (for paging) share clock, reset and keys.
module tb_alu_fpga_seq;

`ifdef ALU_FPGA_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 4;

    logic        clk;
    logic        rst;
    logic [17:0] sw8;
    logic [32:0] sw4;
    logic [3:0]  key;
    logic [55:0] hex8;
    logic [27:0] hex4;
    logic [7:0]  ledg8;
    logic [7:0]  ledg4;

    int total;
    int bad;

    alu_fpga_seq #(.SW_W(18), .DIGITS(8), .DEB_CYCLES(16)) dut8 (
        .CLK  (clk),
        .RST  (rst),
        .SW   (sw8),
        .KEY  (key),
        .HEX  (hex8),
        .LEDG (ledg8)
    );

    alu_fpga_seq #(.SW_W(33), .DIGITS(4), .DEB_CYCLES(16)) dut4 (
        .CLK  (clk),
        .RST  (rst),
        .SW   (sw4),
        .KEY  (key),
        .HEX  (hex4),
        .LEDG (ledg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [2:0]  flg;   // {ovf, neg, zero}
    } vec_t;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] hexw8(input logic [31:0] w);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = glyph(w[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [27:0] hexw4(input logic [15:0] w);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = glyph(w[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        tick(HOLD);
        key[k] = 1'b1;
        tick(HOLD);
    endtask

    vec_t vecs [8];

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{18'h00005, 18'h00003, 4'd0, 32'h00000008, 3'b000};
        vecs[1] = '{18'h3FFFF, 18'h00001, 4'd0, 32'h00000000, 3'b001};
        vecs[2] = '{18'h00003, 18'h00005, 4'd1, 32'hFFFFFFFE, 3'b010};
        vecs[3] = '{18'h0F0F0, 18'h0FF00, 4'd2, 32'h0000F000, 3'b000};
        vecs[4] = '{18'h1ABCD, 18'h0FFFF, 4'd4, 32'h00015432, 3'b000};
        vecs[5] = '{18'h30000, 18'h00ABC, 4'd3, 32'hFFFF0ABC, 3'b010};
        vecs[6] = '{18'h00007, 18'h00007, 4'd1, 32'h00000000, 3'b001};
        vecs[7] = '{18'h3FFFF, 18'h3FFFF, 4'd0, 32'hFFFFFFFE, 3'b010};

        rst = 1'b1;
        key = 4'hF;
        sw8 = '0;
        sw4 = '0;

        // Reset state
        tick(3);
        check("rst_hex", 64'(hex8), 64'(56'hFFFFFFFFFFFFFF));
        check("rst_ledg", 64'(ledg8), 64'h01);
        rst = 1'b0;
        check("post_rst_hex", 64'(hex8), 64'(56'hFFFFFFFFFFFFFF));
        tick(1);
        check("first_hex8", 64'(hex8), 64'(hexw8(32'h0)));
        check("first_hex4", 64'(hex4), 64'(hexw4(16'h0)));
        check("first_ledg", 64'(ledg8), 64'h01);

        // Table-driven full sequences
        for (int i = 0; i < 8; i++) begin
            sw8 = vecs[i].a;
            press(0);
            check($sformatf("v%0d_state_b", i), 64'(ledg8[3:0]), 64'h2);
            sw8 = vecs[i].b;
            press(0);
            sw8 = {14'd0, vecs[i].op};
            tick(2);
            check($sformatf("v%0d_op_hex", i), 64'(hex8), 64'(hexw8({28'd0, vecs[i].op})));
            press(0);
            check($sformatf("v%0d_res_hex", i), 64'(hex8), 64'(hexw8(vecs[i].res)));
            check($sformatf("v%0d_flags", i), 64'(ledg8[6:4]), 64'(vecs[i].flg));
            check($sformatf("v%0d_state_show", i), 64'(ledg8[3:0]), 64'h8);
            press(0);
            check($sformatf("v%0d_back_a", i), 64'(ledg8[3:0]), 64'h1);
        end

        // Paging on the 4-digit instance
        sw4 = {1'b0, 32'hDEADBEEF};
        press(0);
        sw4 = '0;
        press(0);
        press(0);
        check("page0_hex4", 64'(hex4), 64'(hexw4(16'hBEEF)));
        check("page0_led7", 64'(ledg4[7]), 64'h0);
        press(2);
        check("page1_hex4", 64'(hex4), 64'(hexw4(16'hDEAD)));
        check("page1_led7", 64'(ledg4[7]), 64'h1);
        check("page8_stays0", 64'(ledg8[7]), 64'h0);
        press(2);
        check("page_wrap_hex4", 64'(hex4), 64'(hexw4(16'hBEEF)));
        check("page_wrap_led7", 64'(ledg4[7]), 64'h0);
        press(0);
        check("page_exit_a", 64'(ledg4[3:0]), 64'h1);

        // Simultaneous advance and clear in LOAD_B
        sw8 = 18'h12345;
        press(0);
        check("simul_pre_b", 64'(ledg8[3:0]), 64'h2);
        key = 4'b1100;
        tick(HOLD);
        key = 4'hF;
        tick(HOLD);
        check("simul_state_a", 64'(ledg8[3:0]), 64'h1);
        check("simul_hex_sw", 64'(hex8), 64'(hexw8(32'h00012345)));

        // Held advance gives exactly one transition
        key[0] = 1'b0;
        tick(60);
        check("held_one_step", 64'(ledg8[3:0]), 64'h2);
        key[0] = 1'b1;
        tick(HOLD);
        check("held_release", 64'(ledg8[3:0]), 64'h2);
        press(1);
        check("clear_to_a", 64'(ledg8[3:0]), 64'h1);

        // Press latency: LEDG shows the new state one cycle after the transition
        key[0] = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(1);
            if (k == LAT)     check("lat_before", 64'(ledg8[3:0]), 64'h1);
            if (k == LAT + 1) check("lat_after", 64'(ledg8[3:0]), 64'h2);
        end
        key[0] = 1'b1;
        tick(HOLD);
        press(1);

`ifdef ALU_FPGA_DEBOUNCE_EN
        // Short glitch is filtered out
        key[0] = 1'b0;
        tick(10);
        key[0] = 1'b1;
        tick(30);
        check("glitch_no_step", 64'(ledg8[3:0]), 64'h1);
`endif

        // Reset mid-sequence aborts at once
        sw8 = 18'h00042;
        press(0);
        check("abort_pre_b", 64'(ledg8[3:0]), 64'h2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_ledg", 64'(ledg8), 64'h01);
        check("abort_hex", 64'(hex8), 64'(56'hFFFFFFFFFFFFFF));
        tick(2);
        rst = 1'b0;
        tick(2);
        check("abort_state_a", 64'(ledg8), 64'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
